// File: rtl/pulse_pkg.sv
// Frame layout, reset defaults and parameter bundle shared by the loader and the pulse sequencer.
package pulse_pkg;

  localparam logic [7:0] HEADER      = 8'hA5;
  localparam int         PAYLOAD_LEN = 18;

  localparam int OFF_PER      = 0;
  localparam int OFF_P1WID    = 4;
  localparam int OFF_DEL      = 6;
  localparam int OFF_P2WID    = 8;
  localparam int OFF_NUT_W    = 10;
  localparam int OFF_NUT_D    = 11;
  localparam int OFF_CP       = 13;
  localparam int OFF_P_BL     = 14;
  localparam int OFF_P_BL_OFF = 15;
  localparam int OFF_BL       = 17;

  localparam logic [31:0] D_PER      = 32'd4000;
  localparam logic [15:0] D_P1WID    = 16'd30;
  localparam logic [15:0] D_DEL      = 16'd200;
  localparam logic [15:0] D_P2WID    = 16'd60;
  localparam logic [7:0]  D_NUT_W    = 8'd0;
  localparam logic [15:0] D_NUT_D    = 16'd0;
  localparam logic [7:0]  D_CP       = 8'd1;
  localparam logic [7:0]  D_P_BL     = 8'd50;
  localparam logic [15:0] D_P_BL_OFF = 16'd100;
  localparam logic        D_BL       = 1'b1;

  typedef struct packed {
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  nut_w;
    logic [15:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic        bl;
  } pulse_params_t;

  localparam pulse_params_t PARAMS_DEFAULT = '{
    per:      D_PER,
    p1wid:    D_P1WID,
    del:      D_DEL,
    p2wid:    D_P2WID,
    nut_w:    D_NUT_W,
    nut_d:    D_NUT_D,
    cp:       D_CP,
    p_bl:     D_P_BL,
    p_bl_off: D_P_BL_OFF,
    bl:       D_BL
  };

  // Slot 0 is the first payload byte after the header.
  typedef logic [PAYLOAD_LEN-1:0][7:0] payload_t;

  function automatic pulse_params_t unpack_payload(input payload_t b);
    pulse_params_t p;
    logic unused_bl_bits;
    p.per      = {b[OFF_PER], b[OFF_PER+1], b[OFF_PER+2], b[OFF_PER+3]};
    p.p1wid    = {b[OFF_P1WID], b[OFF_P1WID+1]};
    p.del      = {b[OFF_DEL], b[OFF_DEL+1]};
    p.p2wid    = {b[OFF_P2WID], b[OFF_P2WID+1]};
    p.nut_w    = b[OFF_NUT_W];
    p.nut_d    = {b[OFF_NUT_D], b[OFF_NUT_D+1]};
    p.cp       = b[OFF_CP];
    p.p_bl     = b[OFF_P_BL];
    p.p_bl_off = {b[OFF_P_BL_OFF], b[OFF_P_BL_OFF+1]};
    p.bl       = b[OFF_BL][0];
    unused_bl_bits = ^b[OFF_BL][7:1];
    return p;
  endfunction

endpackage

// File: rtl/pulse_param_loader_if.sv
// Serial input and committed parameter bank of the pulse parameter loader.
interface pulse_param_loader_if;
  logic        rxd;
  logic [31:0] per;
  logic [15:0] p1wid;
  logic [15:0] del;
  logic [15:0] p2wid;
  logic [7:0]  nut_w;
  logic [15:0] nut_d;
  logic [7:0]  cp;
  logic [7:0]  p_bl;
  logic [15:0] p_bl_off;
  logic        bl;
  logic        rx_done;
  logic        rx_err;

  modport master (
    input  rxd,
    output per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off, bl,
    output rx_done, rx_err
  );

  modport slave (
    output rxd,
    input  per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off, bl,
    input  rx_done, rx_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit glitch rejection, centre sampling.
//   state   | meaning
//   S_IDLE  | waiting for a falling edge on the synchronized line
//   S_START | counting to the start-bit centre, glitch check
//   S_DATA  | sampling 8 data bits LSB first
//   S_STOP  | sampling the stop bit, bad stop drops the byte
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          rxd_meta;
  logic          rxd_s;
  logic          rxd_q;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_q    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_q    <= rxd_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= 4'd0;
      shreg      <= 8'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
    end else begin
      byte_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rxd_q && !rxd_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_END) begin
            cnt     <= '0;
            bit_cnt <= 4'd0;
            state   <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            shreg   <= {rxd_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (rxd_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pulse_param_loader.sv
// Frames UART bytes into checksummed parameter packets and commits them atomically to the output bank.
//   state     | meaning
//   S_IDLE    | hunting for the header byte
//   S_PAYLOAD | filling shadow slots 0..17, accumulating the checksum
//   S_CHECK   | waiting for the checksum byte
//   S_COMMIT  | new bank visible, rx_done high for this cycle
module pulse_param_loader #(
  parameter int         CLKS_PER_BIT   = 434,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter logic [7:0] HEADER         = pulse_pkg::HEADER
) (
  input logic                  clk,
  input logic                  reset,
  pulse_param_loader_if.master bus
);
  import pulse_pkg::*;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PAYLOAD = 2'd1;
  localparam logic [1:0] S_CHECK   = 2'd2;
  localparam logic [1:0] S_COMMIT  = 2'd3;

  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_END  = GW'(TIMEOUT_CYCLES);
  localparam logic [4:0]    LAST_IDX = 5'(PAYLOAD_LEN - 1);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic [1:0]    state;
  logic [4:0]    idx;
  logic [7:0]    sum;
  logic [GW-1:0] gap;
  logic          gap_hit;
  payload_t      shadow;
  pulse_params_t params;
  logic          rx_err;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_rx (
    .clk       (clk),
    .reset     (reset),
    .rxd       (bus.rxd),
    .byte_valid(byte_valid),
    .byte_data (byte_data)
  );

  assign gap_hit = !byte_valid && (gap == GAP_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      idx    <= 5'd0;
      sum    <= 8'd0;
      gap    <= '0;
      shadow <= '0;
      params <= PARAMS_DEFAULT;
      rx_err <= 1'b0;
    end else begin
      rx_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (byte_valid && byte_data == HEADER) begin
            state <= S_PAYLOAD;
            idx   <= 5'd0;
            sum   <= 8'd0;
            gap   <= '0;
          end
        end
        S_PAYLOAD: begin
          if (byte_valid) begin
            shadow[idx] <= byte_data;
            sum         <= sum + byte_data;
            idx         <= idx + 1'b1;
            gap         <= '0;
            if (idx == LAST_IDX) state <= S_CHECK;
          end else if (gap_hit) begin
            rx_err <= 1'b1;
            state  <= S_IDLE;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        S_CHECK: begin
          if (byte_valid) begin
            if (byte_data == sum) begin
              // Bank is loaded on the edge into COMMIT so rx_done and the new values appear together.
              params <= unpack_payload(shadow);
              state  <= S_COMMIT;
            end else begin
              rx_err <= 1'b1;
              state  <= S_IDLE;
            end
          end else if (gap_hit) begin
            rx_err <= 1'b1;
            state  <= S_IDLE;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_done  = (state == S_COMMIT);
  assign bus.rx_err   = rx_err;
  assign bus.per      = params.per;
  assign bus.p1wid    = params.p1wid;
  assign bus.del      = params.del;
  assign bus.p2wid    = params.p2wid;
  assign bus.nut_w    = params.nut_w;
  assign bus.nut_d    = params.nut_d;
  assign bus.cp       = params.cp;
  assign bus.p_bl     = params.p_bl;
  assign bus.p_bl_off = params.p_bl_off;
  assign bus.bl       = params.bl;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Directed bench for pulse_param_loader with a strobe scoreboard.
module tb_pulse_param_loader;
  import pulse_pkg::*;

  localparam int CPB = 16;
  localparam int TMO = 1000;

  typedef struct {
    logic          is_done;
    pulse_params_t p;
  } exp_t;

  typedef logic [19:0][7:0] frame_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pulse_param_loader_if bus();

  pulse_param_loader #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TMO),
    .HEADER        (8'hA5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t          sb[$];
  exp_t          e;
  int            errors = 0;
  int            checks = 0;
  logic          prev_strobe = 1'b0;
  pulse_params_t def_p, p1, p2;
  frame_t        f1, fb, f2;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic pulse_params_t observed();
    pulse_params_t o;
    o = '{per: bus.per, p1wid: bus.p1wid, del: bus.del, p2wid: bus.p2wid, nut_w: bus.nut_w,
          nut_d: bus.nut_d, cp: bus.cp, p_bl: bus.p_bl, p_bl_off: bus.p_bl_off, bl: bus.bl};
    return o;
  endfunction

  task automatic check_outputs(input string tag, input pulse_params_t x);
    check({tag, ".per"},      bus.per,      x.per);
    check({tag, ".p1wid"},    bus.p1wid,    x.p1wid);
    check({tag, ".del"},      bus.del,      x.del);
    check({tag, ".p2wid"},    bus.p2wid,    x.p2wid);
    check({tag, ".nut_w"},    bus.nut_w,    x.nut_w);
    check({tag, ".nut_d"},    bus.nut_d,    x.nut_d);
    check({tag, ".cp"},       bus.cp,       x.cp);
    check({tag, ".p_bl"},     bus.p_bl,     x.p_bl);
    check({tag, ".p_bl_off"}, bus.p_bl_off, x.p_bl_off);
    check({tag, ".bl"},       bus.bl,       x.bl);
  endtask

  function automatic frame_t make_frame(input pulse_params_t p, input logic [7:0] bl_byte);
    frame_t     f;
    logic [7:0] s;
    f[0]  = 8'hA5;
    f[1]  = p.per[31:24];     f[2]  = p.per[23:16];
    f[3]  = p.per[15:8];      f[4]  = p.per[7:0];
    f[5]  = p.p1wid[15:8];    f[6]  = p.p1wid[7:0];
    f[7]  = p.del[15:8];      f[8]  = p.del[7:0];
    f[9]  = p.p2wid[15:8];    f[10] = p.p2wid[7:0];
    f[11] = p.nut_w;
    f[12] = p.nut_d[15:8];    f[13] = p.nut_d[7:0];
    f[14] = p.cp;
    f[15] = p.p_bl;
    f[16] = p.p_bl_off[15:8]; f[17] = p.p_bl_off[7:0];
    f[18] = bl_byte;
    s = 8'd0;
    for (int i = 1; i <= 18; i++) s = s + f[i];
    f[19] = s;
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rxd = stop;
    repeat (CPB) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input frame_t f, input int first, input int last, input int bad_idx);
    for (int i = first; i <= last; i++) send_byte(f[i], i != bad_idx);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  // Every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (bus.rx_done || bus.rx_err) begin
      check("strobe_exclusive", bus.rx_done && bus.rx_err, 1'b0);
      check("strobe_single_cycle", prev_strobe, 1'b0);
      check("strobe_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("strobe_kind_done", bus.rx_done, e.is_done);
        check("strobe_params", observed(), e.p);
      end
    end
    prev_strobe <= bus.rx_done | bus.rx_err;
  end

  initial begin
    def_p = '{per: 32'd4000, p1wid: 16'd30, del: 16'd200, p2wid: 16'd60, nut_w: 8'd0,
              nut_d: 16'd0, cp: 8'd1, p_bl: 8'd50, p_bl_off: 16'd100, bl: 1'b1};
    p1    = '{per: 32'd8000, p1wid: 16'd40, del: 16'd300, p2wid: 16'd80, nut_w: 8'd0,
              nut_d: 16'd0, cp: 8'd3, p_bl: 8'd50, p_bl_off: 16'd100, bl: 1'b1};
    p2    = '{per: 32'h00012345, p1wid: 16'h0102, del: 16'h0304, p2wid: 16'h0506, nut_w: 8'h07,
              nut_d: 16'h0809, cp: 8'h0A, p_bl: 8'h0B, p_bl_off: 16'h0C0D, bl: 1'b0};
    f1 = make_frame(p1, 8'h01);
    f2 = make_frame(p2, 8'hFE);
    fb = f1;
    fb[19] = 8'h9F;

    bus.rxd = 1'b1;
    reset   = 1'b0;
    repeat (5) @(negedge clk);
    check_outputs("reset_hold", def_p);
    check("reset_strobes", {bus.rx_done, bus.rx_err}, 2'b00);
    reset = 1'b1;
    repeat (1000) @(negedge clk);
    check_outputs("reset_defaults", def_p);

    sb.push_back('{1'b1, p1});
    send_frame(f1, 0, 19, -1);
    drain("valid_drain");
    check_outputs("valid_frame", p1);

    sb.push_back('{1'b0, p1});
    send_frame(fb, 0, 19, -1);
    drain("badsum_drain");
    check_outputs("badsum_hold", p1);
    sb.push_back('{1'b1, p2});
    send_frame(f2, 0, 19, -1);
    drain("after_badsum_drain");
    check_outputs("after_badsum", p2);

    sb.push_back('{1'b0, p2});
    send_frame(f1, 0, 5, -1);
    repeat (TMO + 10) @(negedge clk);
    drain("timeout_drain");
    check_outputs("timeout_hold", p2);
    sb.push_back('{1'b1, p1});
    send_frame(f1, 0, 19, -1);
    drain("after_timeout_drain");
    check_outputs("after_timeout", p1);

    send_byte(8'hA5, 1'b0);
    bus.rxd = 1'b0;
    repeat (5) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check_outputs("glitch_hold", p1);

    // Dropped byte 5 pulls the checksum into slot 17, so the frame dies by timeout in CHECK.
    sb.push_back('{1'b0, p1});
    send_frame(f2, 0, 19, 5);
    repeat (TMO + 10) @(negedge clk);
    drain("badstop_drain");
    check_outputs("badstop_hold", p1);

    send_frame(f2, 0, 9, -1);
    reset = 1'b0;
    #1;
    check_outputs("midreset_defaults", def_p);
    check("midreset_strobes", {bus.rx_done, bus.rx_err}, 2'b00);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(f2, 10, 19, -1);
    repeat (50) @(negedge clk);
    check_outputs("aborted_tail", def_p);
    sb.push_back('{1'b1, p2});
    send_frame(f2, 0, 19, -1);
    drain("fresh_frame_drain");
    check_outputs("fresh_frame", p2);

    repeat (20) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_param_loader.md
# pulse_param_loader

Serial front end for the pulse sequencer. Receives 8N1 UART bytes on `rxd` and frames them into fixed-length parameter packets with a checksum. Commits each validated packet atomically to a bank of holding registers that drive the sequencer's `per`/`p1wid`/…/`bl` inputs, and emits a one-cycle `rx_done` strobe on each commit. Runs in the 50 MHz `clk` domain, upstream of `pulses`.

## Interface
- `CLKS_PER_BIT`, 434: `clk` cycles per UART bit (50 MHz / 115200).
- `TIMEOUT_CYCLES`, 500000: maximum idle gap between bytes inside a frame (10 ms).
- `HEADER`, 8'hA5: frame start byte.
- `D_PER`, `D_P1WID`, `D_DEL`, `D_P2WID`, `D_NUT_W`, `D_NUT_D`, `D_CP`, `D_P_BL`, `D_P_BL_OFF`, `D_BL`: reset values 4000, 30, 200, 60, 0, 0, 1, 50, 100, 1.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `rxd`  in  1  UART receive line, asynchronous, idles high.
- `per`  out  32  period.
- `p1wid`, `del`, `p2wid`, `nut_d`, `p_bl_off`  out  16 each  pulse-timing fields.
- `nut_w`, `cp`, `p_bl`  out  8 each  nutation width, CPMG count, block-open start.
- `bl`  out  1  blocking enable.
- `rx_done`  out  1  one-cycle strobe on commit.
- `rx_err`  out  1  one-cycle strobe when a frame is rejected (checksum mismatch or timeout).

## Operation
- **Frame format:** `HEADER`, then 18 payload bytes, then 1 checksum byte (20 bytes total).
  - Payload order, multi-byte fields MSB first: `per`(4), `p1wid`(2), `del`(2), `p2wid`(2), `nut_w`(1), `nut_d`(2), `cp`(1), `p_bl`(1), `p_bl_off`(2), `bl`(1).
  - Only bit 0 of the `bl` byte is used.
  - Checksum is the 8-bit sum, modulo 256, of the 18 payload bytes.
- **UART RX:**
  - `rxd` passes through a 2-flop synchronizer.
  - A falling edge starts reception. The start bit is re-sampled at `CLKS_PER_BIT/2`; if it reads high, the edge is a glitch and the receiver returns to idle.
  - Data bits are sampled at bit centres, LSB first.
  - The stop bit is sampled at its centre. If it is 0, the byte is dropped silently: no `byte_valid`, no `rx_err`.
  - Otherwise `byte_valid` pulses for one cycle with `byte_data`.
- **Parser FSM:**
  - IDLE: a valid byte equal to `HEADER` moves to PAYLOAD with `idx`=0 and `sum`=0. Any other byte is discarded.
  - PAYLOAD: each byte is written to shadow slot `idx`, `sum` += byte, `idx`++. After `idx`=17, go to CHECK.
  - CHECK: the next byte is compared with `sum`.
    - Match: go to COMMIT.
    - Mismatch: pulse `rx_err`, go to IDLE.
  - COMMIT: for one cycle, copy the shadow bank into the output registers, pulse `rx_done`, go to IDLE.
- Outputs change only in COMMIT. A partial or failed frame never alters any output.
- Payload bytes equal to `HEADER` are ordinary data; there is no escaping or resync.
- **Timeout:** in PAYLOAD or CHECK, a gap counter resets on every `byte_valid`. When it reaches `TIMEOUT_CYCLES`, pulse `rx_err` and go to IDLE.
- Values are committed unchecked; semantic range checking belongs downstream.

## Timing
- **Reset:** asserting `reset` (low) at any time, including mid-byte or mid-frame, immediately forces:
  - the FSM to IDLE, `idx` and `sum` to 0, and the UART to idle;
  - all parameter outputs to their `D_*` values;
  - `rx_done` and `rx_err` to 0.
- A frame in progress at reset is lost; reception restarts cleanly at the next start bit after reset is released.
- `byte_valid` fires `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles after the start-bit falling edge is seen at the synchronizer output (±1 cycle).
- The checksum `byte_valid` in cycle N gives state COMMIT in N+1. In N+1, `rx_done`=1 and the new outputs are visible. All output fields update in the same edge.
- The checksum mismatch `rx_err` is asserted in cycle N+1.
- A header arriving at the earliest legal time after a commit is accepted, so back-to-back frames lose no bytes.
- `rx_done` and `rx_err` are never high simultaneously and never high for more than 1 cycle.
- Counter widths: bit counter 4 bits, baud counter `$clog2(CLKS_PER_BIT)` bits, gap counter `$clog2(TIMEOUT_CYCLES+1)` bits, `idx` 5 bits, `sum` 8 bits wrapping.

## Structure
- **Shared package** `pulse_pkg`:
  - frame constants: `HEADER`, payload length 18, field byte offsets;
  - the reset-default constants, shared with `pulses` so both blocks agree;
  - a packed struct `pulse_params_t` holding all ten fields.
- **Sub-module** `uart_rx`:
  - contains the synchronizer, baud counter and bit FSM;
  - interface: `clk`, `reset`, `rxd` → `byte_valid`, `byte_data[7:0]`.
- The parser and shadow bank stay in `pulse_param_loader`.

## Test plan
- **Reset defaults:** drive `reset` low, then release, then idle 1000 cycles → `per`=4000, `p1wid`=30, `del`=200, `p2wid`=60, `cp`=1, `p_bl`=50, `p_bl_off`=100, `bl`=1, `nut_*`=0, no strobes.
- **Valid frame:** send A5 00 00 1F 40 00 28 01 2C 00 50 00 00 00 03 32 00 64 01 9E → one `rx_done` cycle; then `per`=8000, `p1wid`=40, `del`=300, `p2wid`=80, `cp`=3, `bl`=1.
- **Bad checksum:** the same frame with checksum 9F → one `rx_err` cycle; outputs keep their previous values. A following correct frame commits normally.
- **Timeout:** send A5 plus 5 payload bytes, then idle for `TIMEOUT_CYCLES`+10 → `rx_err` once, outputs unchanged. A following valid frame commits.
- **Framing and glitch:** a byte with stop bit 0 is dropped with no strobe. A 100-cycle low pulse on `rxd` produces no byte. A frame containing one bad-stop byte is later rejected by timeout or checksum.
- **Reset mid-frame:** assert `reset` after 10 bytes of a frame → outputs go to defaults immediately. The remainder of the aborted frame is discarded in IDLE; a fresh full frame commits.
